image_buffer: RTL and testbench
===============================

# image_buffer

Sits directly downstream of the UART router's image channel and consumes its byte stream: 784 pixel bytes followed by the two end-marker bytes 0x66, 0xBB. It writes pixels into a two-bank (ping-pong) image RAM, checks the trailer, and commits each good frame to the conv-layer front end. A new image can therefore be received while inference runs on the previous one.

## Interface
Parameters:
- IMAGE_SIZE, 784, pixel bytes per frame.
- TIMEOUT_CYCLES, 1_000_000, idle cycles mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; the block has one clock.
- image_rx_data  in  8  byte from the router; valid only when image_rx_ready is high.
- image_rx_ready  in  1  one-cycle strobe, one per byte.
- rd_addr  in  10  pixel address (0..783) into the read bank.
- rd_data  out  8  pixel at rd_addr, registered, 1-cycle latency.
- image_valid  out  1  at least one committed image is held; rd_data comes from the oldest one.
- image_release  in  1  one-cycle pulse from the consumer: the oldest image is finished and its bank is freed.
- image_count  out  2  committed images held, 0..2.
- frame_done  out  1  one-cycle pulse: a frame was committed.
- frame_err  out  1  one-cycle pulse: bad trailer or timeout; the frame is discarded.
- frame_drop  out  1  one-cycle pulse: a frame ended while both banks were full; the frame is discarded.

## Operation
- Every output resets to 0.
- rst also clears: byte counter, timeout counter, wr_bank, rd_bank, count, and FSM state (IDLE). RAM contents are not cleared.
- FSM states and transitions:
  - IDLE: the first image_rx_ready starts a frame. That byte is pixel 0. Go to RECV.
  - RECV: on each strobe, write the byte at address {wr_bank, byte_cnt} and increment byte_cnt. After the strobe that takes byte_cnt to IMAGE_SIZE, go to TRL1.
  - TRL1: the next byte is latched and compared with 0x66. Go to TRL2.
  - TRL2: the next byte is compared with 0xBB. Go to COMMIT.
  - COMMIT: lasts one cycle, then return to IDLE.
- Both trailer bytes are always consumed, even if the first one mismatches, so that frame alignment with the router is kept.
- COMMIT outcomes:
  - Both markers matched and count < 2: set full, toggle wr_bank, increment count, pulse frame_done.
  - Any marker mismatched: pulse frame_err; no state change.
  - Both markers matched but count was 2 when the frame started: pulse frame_drop.
- Drop mode: if count == 2 at frame start (the IDLE to RECV transition), the whole frame is counted but no RAM writes happen.
- Release handling:
  - image_release with count > 0: toggle rd_bank and decrement count.
  - image_release with count == 0: ignored.
- Commit and release in the same cycle: both pointers toggle and count is unchanged.
- Timeout: a counter clears on every strobe and in IDLE. In RECV, TRL1 or TRL2, reaching TIMEOUT_CYCLES sends the FSM to IDLE with a frame_err pulse and no commit.
- A strobe that arrives during COMMIT is treated as pixel 0 of the next frame. COMMIT must still perform its IDLE action in that cycle.
- image_valid equals (count != 0) and is driven from a register.
- The read port is always active. Reading while count == 0 returns don't-care data.

## Timing
- Pixel write: in the same cycle as its image_rx_ready.
- Last trailer byte strobed at cycle T:
  - COMMIT at T+1.
  - frame_done / frame_err / frame_drop at T+2.
  - image_valid and image_count updated at T+2.
- rd_addr presented at cycle C gives rd_data at C+1.
- image_release at cycle C: image_count updates at C+1, and rd_bank switches at C+1. Data from the new bank is visible for an address presented at C+1.
- Back-to-back frames with no gap are supported: no byte is lost.

## Structure
- Shared package cnn_pkg holds:
  - IMAGE_SIZE
  - IMAGE_END1 = 8'h66 and IMAGE_END2 = 8'hBB, shared with the router
  - the FSM state encoding
- Sub-module image_bank_ram:
  - simple dual-port RAM, 2048 x 8, address {bank, addr[9:0]}
  - one synchronous write port and one registered read port
  - inferable as a single BRAM
- Top level holds the FSM, the counters and the bank bookkeeping. Expected size is about 150-250 lines.

## Test plan
- Single frame: send pixels with value i mod 256, then 66, BB. Expect frame_done, image_count=1, and rd_data(rd_addr=5)=0x05 one cycle after the address is presented. The contents must still be readable after the next frame starts.
- Bad trailer: send 784 pixels, then 66, 00. Expect a frame_err pulse, image_count=0, and a following good frame to commit normally (alignment kept).
- Two frames with no release: image_count=2. A third good frame gives a frame_drop pulse and count stays 2. Then release: count=1 and reads return frame 2's data.
- Simultaneous: image_release asserted in the same cycle the commit takes effect, with count=1. Expect count to stay 1 and the reads to return the new frame.
- Timeout (TIMEOUT_CYCLES=100 in the bench): stop after 300 pixels for 100 idle cycles. Expect a frame_err pulse, IDLE, and a clean receive of the next frame.
- Reset mid-frame at byte 400: all outputs read 0 and the next full frame commits with count=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Definitions shared by the UART router and the image buffer: frame geometry,
// end-of-frame markers and the image-receive FSM encoding.
package cnn_pkg;

  localparam int         IMAGE_SIZE = 784;
  localparam logic [7:0] IMAGE_END1 = 8'h66;
  localparam logic [7:0] IMAGE_END2 = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_TRL1,
    ST_TRL2,
    ST_COMMIT
  } img_state_t;

endpackage

// File: rtl/image_bank_ram.sv
// Two-bank image store, 2048 x 8: bank select is the address MSB.
// One synchronous write port and one registered read port, maps to a single BRAM.
module image_bank_ram (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [10:0] waddr,
  input  logic [7:0]  wdata,
  input  logic [10:0] raddr,
  output logic [7:0]  rdata
);

  logic [7:0] mem [0:2047];

  // NOTE: the array itself is never reset; a reset loop over 2048 words would
  // stop it mapping to block RAM, and stale pixels are never read as valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/image_buffer.sv
// Receives pixel frames from the router into a ping-pong image RAM, checks the
// two-byte trailer and hands committed frames to the conv front end.
module image_buffer #(
  parameter int IMAGE_SIZE     = cnn_pkg::IMAGE_SIZE,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] image_rx_data,
  input  logic       image_rx_ready,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       image_valid,
  input  logic       image_release,
  output logic [1:0] image_count,
  output logic       frame_done,
  output logic       frame_err,
  output logic       frame_drop
);

  import cnn_pkg::*;

  localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0] LAST_PIX = 10'(IMAGE_SIZE - 1);

  img_state_t       state, state_next;
  logic [9:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             wr_bank, rd_bank, wr_bank_next, rd_bank_next;
  logic [1:0]       count, count_next;
  logic             drop, m1_ok, m2_ok;
  logic             start, start_drop, recv_step, recv_we, tmo_hit, timeout;
  logic             commit_ok, commit_err, commit_drop, release_ok;
  logic             ram_we;
  logic [10:0]      ram_waddr;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves one unassigned and infers a latch.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    recv_step   = 1'b0;
    recv_we     = 1'b0;
    timeout     = 1'b0;
    commit_ok   = 1'b0;
    commit_err  = 1'b0;
    commit_drop = 1'b0;
    case (state)
      ST_IDLE: start = image_rx_ready;
      ST_RECV: begin
        if (image_rx_ready) begin
          recv_step = 1'b1;
          recv_we   = !drop;
          if (byte_cnt == LAST_PIX) state_next = ST_TRL1;
        end else begin
          timeout = tmo_hit;
        end
      end
      ST_TRL1: if (image_rx_ready) state_next = ST_TRL2; else timeout = tmo_hit;
      ST_TRL2: if (image_rx_ready) state_next = ST_COMMIT; else timeout = tmo_hit;
      ST_COMMIT: begin
        state_next = ST_IDLE;
        // A strobe here is pixel 0 of the next frame, handled as in IDLE.
        start      = image_rx_ready;
        if (!(m1_ok && m2_ok)) commit_err  = 1'b1;
        else if (drop)         commit_drop = 1'b1;
        else                   commit_ok   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (timeout) state_next = ST_IDLE;
    if (start)   state_next = ST_RECV;
  end

  // Bank bookkeeping; a frame starting in the commit cycle already sees the
  // post-commit write bank and occupancy.
  always_comb begin
    release_ok   = image_release && (count != 2'd0);
    wr_bank_next = wr_bank ^ commit_ok;
    rd_bank_next = rd_bank ^ release_ok;
    count_next   = count;
    if (commit_ok && !release_ok)      count_next = count + 2'd1;
    else if (!commit_ok && release_ok) count_next = count - 2'd1;
    start_drop = (count_next == 2'd2);
    ram_we     = (start && !start_drop) || recv_we;
    ram_waddr  = {wr_bank_next, (start ? 10'd0 : byte_cnt)};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      count       <= 2'd0;
      drop        <= 1'b0;
      m1_ok       <= 1'b0;
      m2_ok       <= 1'b0;
      image_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      state       <= state_next;
      wr_bank     <= wr_bank_next;
      rd_bank     <= rd_bank_next;
      count       <= count_next;
      image_valid <= (count_next != 2'd0);
      frame_done  <= commit_ok;
      frame_err   <= commit_err || timeout;
      frame_drop  <= commit_drop;

      if (start) begin
        byte_cnt <= 10'd1;
        drop     <= start_drop;
      end else if (recv_step) begin
        byte_cnt <= byte_cnt + 10'd1;
      end

      if (state == ST_IDLE || state == ST_COMMIT || image_rx_ready || timeout)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;

      if (state == ST_TRL1 && image_rx_ready) m1_ok <= (image_rx_data == IMAGE_END1);
      if (state == ST_TRL2 && image_rx_ready) m2_ok <= (image_rx_data == IMAGE_END2);
    end
  end

  assign image_count = count;

  image_bank_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (image_rx_data),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_image_buffer.sv
// Scoreboard bench for image_buffer: expected pixels and frame outcomes are
// queued as stimulus is driven and popped when the DUT reads out or pulses.
module tb_image_buffer;

  localparam int IMG = 784;
  localparam int TMO = 100;

  localparam logic [2:0] EV_DONE = 3'b001;
  localparam logic [2:0] EV_ERR  = 3'b010;
  localparam logic [2:0] EV_DROP = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] image_rx_data;
  logic       image_rx_ready;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       image_valid;
  logic       image_release;
  logic [1:0] image_count;
  logic       frame_done, frame_err, frame_drop;

  int total = 0;
  int bad   = 0;

  logic       rd_req = 1'b0;
  logic [7:0] rd_q[$];
  logic [2:0] ev_q[$];

  image_buffer #(.IMAGE_SIZE(IMG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .image_rx_data  (image_rx_data),
    .image_rx_ready (image_rx_ready),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .image_valid    (image_valid),
    .image_release  (image_release),
    .image_count    (image_count),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .frame_drop     (frame_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int i);
    return 8'((i + seed * 37) & 255);
  endfunction

  // Scoreboard consumers, sampled just after the active edge.
  always @(posedge clk) begin
    #2;
    if (rd_req) begin
      if (rd_q.size() == 0) check("rd_underflow", 32'd1, 32'd0);
      else                  check("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
    end
    if (frame_done || frame_err || frame_drop) begin
      if (ev_q.size() == 0) check("evt_unexpected", {29'd0, frame_drop, frame_err, frame_done}, 32'd0);
      else                  check("evt", {29'd0, frame_drop, frame_err, frame_done}, {29'd0, ev_q.pop_front()});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // All driver tasks start and end on a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    image_rx_data  = b;
    image_rx_ready = 1'b1;
    @(negedge clk);
    image_rx_ready = 1'b0;
  endtask

  task automatic send_pixels(input int seed, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(pix(seed, i));
  endtask

  task automatic send_trailer(input logic [7:0] e2, input logic [2:0] ev);
    ev_q.push_back(ev);
    send_byte(8'h66);
    send_byte(e2);
  endtask

  task automatic send_frame(input int seed, input logic [7:0] e2, input logic [2:0] ev);
    send_pixels(seed, 0, IMG - 1);
    send_trailer(e2, ev);
  endtask

  task automatic read_px(input int addr, input logic [7:0] exp);
    rd_addr = 10'(addr);
    rd_req  = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  task automatic read_frame(input int seed);
    int addrs[5] = '{0, 1, 5, 255, IMG - 1};
    foreach (addrs[k]) read_px(addrs[k], pix(seed, addrs[k]));
  endtask

  task automatic release_one();
    image_release = 1'b1;
    @(negedge clk);
    image_release = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_count"}, {30'd0, image_count}, 32'd0);
    check({tag, "_valid"}, {31'd0, image_valid}, 32'd0);
    check({tag, "_flags"}, {29'd0, frame_drop, frame_err, frame_done}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    image_rx_data  = 8'h00;
    image_rx_ready = 1'b0;
    rd_addr        = 10'd0;
    image_release  = 1'b0;
    cycles(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    cycles(2);

    // Single good frame, pixels i mod 256.
    send_frame(0, 8'hBB, EV_DONE);
    cycles(2);
    check("single_count", {30'd0, image_count}, 32'd1);
    check("single_valid", {31'd0, image_valid}, 32'd1);
    read_frame(0);

    // Frame 0 still readable after the next frame has started.
    send_pixels(1, 0, 9);
    read_px(5, 8'h05);
    read_px(783, pix(0, 783));
    release_one();
    send_pixels(1, 10, IMG - 1);
    send_trailer(8'h00, EV_ERR);
    cycles(2);
    check("badtrl_count", {30'd0, image_count}, 32'd0);
    check("badtrl_valid", {31'd0, image_valid}, 32'd0);

    // Alignment kept: next good frame commits.
    send_frame(2, 8'hBB, EV_DONE);
    cycles(2);
    check("realign_count", {30'd0, image_count}, 32'd1);
    read_frame(2);

    // Fill both banks, third frame is dropped.
    send_frame(3, 8'hBB, EV_DONE);
    cycles(2);
    check("full_count", {30'd0, image_count}, 32'd2);
    send_frame(4, 8'hBB, EV_DROP);
    cycles(2);
    check("drop_count", {30'd0, image_count}, 32'd2);
    read_frame(2);
    release_one();
    check("rel_count", {30'd0, image_count}, 32'd1);
    read_frame(3);

    // Release lands in the commit cycle while one image is held.
    send_frame(5, 8'hBB, EV_DONE);
    image_release = 1'b1;
    @(negedge clk);
    image_release = 1'b0;
    @(negedge clk);
    check("simul_count", {30'd0, image_count}, 32'd1);
    check("simul_valid", {31'd0, image_valid}, 32'd1);
    read_frame(5);

    // Back-to-back frames, next pixel 0 arrives during commit.
    release_one();
    check("b2b_pre_count", {30'd0, image_count}, 32'd0);
    send_frame(6, 8'hBB, EV_DONE);
    send_frame(7, 8'hBB, EV_DONE);
    cycles(2);
    check("b2b_count", {30'd0, image_count}, 32'd2);
    read_frame(6);
    release_one();
    read_frame(7);
    release_one();
    check("b2b_post_count", {30'd0, image_count}, 32'd0);

    // Mid-frame stall triggers a timeout, then a clean receive.
    ev_q.push_back(EV_ERR);
    send_pixels(8, 0, 299);
    cycles(TMO + 10);
    check("tmo_count", {30'd0, image_count}, 32'd0);
    send_frame(9, 8'hBB, EV_DONE);
    cycles(2);
    check("tmo_next_count", {30'd0, image_count}, 32'd1);
    read_frame(9);

    // Reset in the middle of a frame.
    send_pixels(10, 0, 399);
    rst = 1'b1;
    cycles(2);
    check_outputs_zero("midrst");
    rst = 1'b0;
    cycles(2);
    send_frame(11, 8'hBB, EV_DONE);
    cycles(2);
    check("midrst_next_count", {30'd0, image_count}, 32'd1);
    read_frame(11);

    cycles(4);
    check("evt_pending", ev_q.size(), 32'd0);
    check("rd_pending", rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
